// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM port widths and reader FSM state type
package ram_pkg;

  localparam int RAM_ADDR_W = 19;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_SPACE,
    ST_DRAIN,
    ST_FLUSH
  } rd_state_t;

endpackage

// File: rtl/ram_reader_fifo.sv
// rtl/ram_reader_fifo.sv - synchronous shift FIFO with registered head word, count and flags
module ram_reader_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              pop;
  logic              push;
  logic [PTR_W-1:0]  widx;
  logic [CNT_W-1:0]  count_d;

  // Qualify push/pop against occupancy; a write into a full FIFO is legal only alongside a read.
  always_comb begin
    pop     = rd_en && (count != '0);
    push    = wr_en && ((count != CNT_FULL) || pop);
    widx    = pop ? PTR_W'(count - 1'b1) : PTR_W'(count);
    count_d = count + CNT_W'(push) - CNT_W'(pop);
    if (clr) begin
      count_d = '0;
    end
  end

  // Entries shift toward slot 0 on a pop so the head is always a flop; a push lands after the last valid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (!clr) begin
        if (pop) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            mem[PTR_W'(i)] <= mem[PTR_W'(i + 1)];
          end
        end
        if (push) begin
          mem[widx] <= wr_data;
        end
      end
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == CNT_FULL);
    end
  end

  assign rd_data = mem[{PTR_W{1'b0}}];

endmodule

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - RAM burst reader to stream; RAM_READER_FIFO_EN selects a FIFO instead of one output register
module ram_reader
  import ram_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rvalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  rd_state_t         state;
  rd_state_t         state_d;
  logic              busy_d;
  logic              done_d;
  logic              ren_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] rem_d;
  logic              push;
  logic              pop;
  logic              clr;
  logic              space;
  logic              buf_empty;

  assign pop = out_valid && out_ready;

  // Burst sequencing: one read in flight, ren dropped on the completing edge, abort drains through FLUSH.
  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    ren_d   = ram_ren;
    addr_d  = ram_addr;
    rem_d   = remaining;
    push    = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          addr_d = start_addr;
          rem_d  = len;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_REQ;
            ren_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = ST_FLUSH;
          if (ram_rvalid) begin
            ren_d = 1'b0;
          end
        end else if (ram_rvalid) begin
          push    = 1'b1;
          ren_d   = 1'b0;
          addr_d  = ram_addr + 1'b1;
          rem_d   = remaining - 1'b1;
          state_d = (remaining == ADDR_W'(1)) ? ST_DRAIN : ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = ST_FLUSH;
        end else if (space) begin
          state_d = ST_REQ;
          ren_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = ST_FLUSH;
        end else if (buf_empty) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        clr = 1'b1;
        if (!ram_ren || ram_rvalid) begin
          ren_d   = 1'b0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_ren   <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      ram_ren   <= ren_d;
      ram_addr  <= addr_d;
      remaining <= rem_d;
    end
  end

`ifdef RAM_READER_FIFO_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  ram_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (push),
    .wr_data (ram_rdata),
    .rd_en   (pop),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign space     = !fifo_full;
  assign buf_empty = (fifo_count == '0);
`else
  // Single holding register: the next read waits until the held word has gone downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (push) begin
      out_data  <= ram_rdata;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  assign space     = !out_valid;
  assign buf_empty = !out_valid;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - randomized scoreboard bench for ram_reader with a behavioural RAM responder
module tb_ram_reader;

  localparam int AW    = 19;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef RAM_READER_FIFO_EN
  localparam int RD_LIMIT = DEPTH;
`else
  localparam int RD_LIMIT = 1;
`endif

  logic          tb_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] len = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_rvalid = 1'b0;
  logic          busy, done, ram_ren, out_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] out_data;

  always #5 tb_clk = ~tb_clk;

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(tb_clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_ren(ram_ren),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  int            reads_issued = 0;
  int            done_cnt = 0;
  bit            rand_ready = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] mem [bit [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return DW'(a) ^ 16'hA5C3;
  endfunction

  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a, input int i);
    return AW'((int'(a) + i) % (1 << AW));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit expect_words);
    if (expect_words) begin
      for (int i = 0; i < int'(l); i++) exp_q.push_back(mem_rd(wrap_addr(a, i)));
    end
    start_addr = a;
    len        = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string name);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (!busy) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ren"}, 32'(ram_ren), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  // RAM responder: answers each ren with one rvalid after 0..3 wait cycles.
  initial begin : responder
    logic [AW-1:0] a;
    int            lat;
    forever begin
      tick();
      if (ram_ren && !rst) begin
        a = ram_addr;
        reads_issued++;
        rd_log.push_back(a);
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          tick();
          if (busy) begin
            check("ren_held", 32'(ram_ren), 32'd1);
            check("addr_stable", 32'(ram_addr), 32'(a));
          end
        end
        ram_rdata  = mem_rd(a);
        ram_rvalid = 1'b1;
        tick();
        ram_rvalid = 1'b0;
        ram_rdata  = DW'($urandom);
      end
    end
  end

  initial begin : ready_gen
    forever begin
      tick();
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks hold/ren-gap rules.
  initial begin : monitor
    logic          p_rvalid = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_abort = 1'b0, p_rst = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge tb_clk);
      if (p_rvalid && !rst) check("ren_gap", 32'(ram_ren), 32'd0);
      if (p_valid && !p_ready && !p_abort && !p_rst) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(p_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
      if (done) done_cnt++;
      p_rvalid = ram_rvalid;
      p_valid  = out_valid;
      p_ready  = out_ready;
      p_data   = out_data;
      p_abort  = abort;
      p_rst    = rst;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int            r0, d0, nrise;
    logic          prev;
    logic [AW-1:0] a, l;

    mem[19'd4] = 16'hDEAD;
    mem[19'd5] = 16'hBEEF;
    mem[19'd6] = 16'hBABE;
    for (int i = 7; i < 64; i++) mem[AW'(i)] = DW'($urandom);
    for (int i = 0; i < 16; i++) mem[AW'(19'h7FFF0 + i)] = DW'($urandom);

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic burst
    out_ready = 1'b1;
    d0 = done_cnt;
    start_burst(19'd4, 19'd3, 1'b1);
    wait_done(60, "basic_done");
    tick();
    check("basic_one_done", 32'(done_cnt - d0), 32'd1);
    check("basic_drained", 32'(exp_q.size()), 32'd0);
    check("basic_busy", 32'(busy), 32'd0);

    // Zero length
    r0 = reads_issued;
    start_burst(19'd100, 19'd0, 1'b1);
    wait_done(2, "zero_done");
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_no_reads", 32'(reads_issued - r0), 32'd0);

    // Start together with abort in IDLE
    r0 = reads_issued;
    start_addr = 19'd4;
    len = 19'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("start_abort_no_read", 32'(reads_issued - r0), 32'd0);

    // Address wrap
    rd_log.delete();
    start_burst(19'h7FFFE, 19'd4, 1'b1);
    wait_done(80, "wrap_done");
    tick();
    check("wrap_reads", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) check("wrap_addr", 32'(rd_log[i]), 32'(wrap_addr(19'h7FFFE, i)));

    // Backpressure, plus a start while busy that must be ignored
    out_ready = 1'b0;
    r0 = reads_issued;
    start_burst(19'd30, 19'd8, 1'b1);
    repeat (5) tick();
    start_burst(19'd200, 19'd2, 1'b0);
    repeat (15) tick();
    check("bp_reads_within_limit", 32'((reads_issued - r0) <= RD_LIMIT), 32'd1);
    check("bp_some_read", 32'((reads_issued - r0) >= 1), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done(200, "bp_done");
    tick();
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_total_reads", 32'(reads_issued - r0), 32'd8);

    // Abort while the second read is in flight
    d0 = done_cnt;
    exp_q.push_back(mem_rd(19'd10));
    start_burst(19'd10, 19'd6, 1'b0);
    prev = ram_ren;
    nrise = ram_ren ? 1 : 0;
    for (int i = 0; i < 60 && nrise < 2; i++) begin
      tick();
      if (ram_ren && !prev) nrise++;
      prev = ram_ren;
    end
    check("abort_second_read_seen", 32'(nrise), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(20, "abort_idle");
    check("abort_valid_low", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_first_word_only", 32'(exp_q.size()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    start_burst(19'd4, 19'd1, 1'b1);
    wait_done(40, "after_abort_done");
    tick();
    check("after_abort_drained", 32'(exp_q.size()), 32'd0);

    // Reset while stalled in WAIT_SPACE
    out_ready = 1'b0;
    start_burst(19'd50, 19'd8, 1'b0);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("midrst_idle", 32'(busy), 32'd0);
    start_burst(19'd4, 19'd3, 1'b1);
    wait_done(60, "midrst_burst_done");
    tick();
    check("midrst_drained", 32'(exp_q.size()), 32'd0);

    // Random bursts with random downstream readiness
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = (k % 2 == 1) ? AW'(19'h7FFF0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 63));
      l = AW'($urandom_range(0, 9));
      start_burst(a, l, 1'b1);
      wait_done(400, "rand_done");
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter ADDR_W, default 19, word address width of the RAM controller port.
REQ-002 Parameter DATA_W, default 16, RAM word width.
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO depth in words, power of two and at least 2.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-007 start_addr  input  ADDR_W  first word address, sampled when start is accepted.
REQ-008 len  input  ADDR_W  word count, sampled when start is accepted.
REQ-009 abort  input  1  cancels the active burst.
REQ-010 busy  output  1  high from an accepted start until done or abort completes.
REQ-011 done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-012 ram_addr  output  ADDR_W  address to the ramctl addr port.
REQ-013 ram_ren  output  1  read request to the ramctl ren port.
REQ-014 ram_rdata  input  DATA_W  ramctl read data; valid only while ram_rvalid=1.
REQ-015 ram_rvalid  input  1  ramctl read-complete strobe.
REQ-016 out_data  output  DATA_W  stream data, taken from the FIFO head.
REQ-017 out_valid  output  1  stream valid; a transfer occurs when out_valid=1 and out_ready=1.
REQ-018 out_ready  input  1  downstream ready.

Function
REQ-019 FSM states: IDLE, REQ, WAIT_SPACE, DRAIN, FLUSH; all outputs registered.
REQ-020 IDLE + start: latch the address and remaining=len, then enter REQ; if len=0, enter DRAIN directly and issue no reads.
REQ-021 REQ: ram_ren=1 with ram_addr held stable until ram_rvalid is sampled high.
REQ-022 On ram_rvalid: write ram_rdata to the FIFO, drop ram_ren on that same edge, increment the address, decrement remaining.
REQ-023 Address arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 is followed by 0.
REQ-024 Exactly one read is outstanding at any time; ram_ren stays low for at least one cycle between reads.
REQ-025 A new read is issued only when the FIFO has a free slot that accounts for the outstanding read; otherwise the FSM sits in WAIT_SPACE.
REQ-026 When remaining reaches 0, enter DRAIN; when the FIFO is empty, pulse done and return to IDLE with busy=0 in the same cycle.
REQ-027 FIFO empty: out_valid=0. FIFO full: no read issued. A simultaneous FIFO write and read keeps the occupancy unchanged.
REQ-028 out_data and out_valid are held stable while out_valid=1 and out_ready=0.
REQ-029 abort during REQ: enter FLUSH and wait for ram_rvalid, discarding its data.
REQ-030 abort in any other busy state: enter FLUSH immediately.
REQ-031 FLUSH empties the FIFO, sets out_valid=0, returns to IDLE, and does not pulse done.
REQ-032 abort together with start in IDLE: abort wins and start is ignored.
REQ-033 start while busy: ignored, with no effect on the latched parameters.

Reset
REQ-034 On rst: state=IDLE, busy=0, done=0, ram_ren=0, ram_addr=0, out_valid=0, out_data=0, FIFO empty, remaining=0.
REQ-035 rst mid-burst abandons the burst immediately; any later ram_rvalid arriving in IDLE is ignored.

Configuration
REQ-036 Macro RAM_READER_FIFO_EN defined: the FIFO_DEPTH-entry FIFO is instantiated and reads run ahead of the downstream consumer.
REQ-037 Macro RAM_READER_FIFO_EN undefined: a single output register replaces the FIFO and FIFO_DEPTH is ignored.
REQ-038 Without RAM_READER_FIFO_EN, the next read is issued only after the held word has been transferred downstream.

Structure
REQ-039 Package ram_pkg holds RAM_ADDR_W=19, RAM_DATA_W=16 and the FSM state enum type; ramctl and ram_reader share it.
REQ-040 Sub-module ram_reader_fifo is a synchronous FIFO with registered output and full/empty/count ports, instantiated only under RAM_READER_FIFO_EN.

Verification
REQ-041 Bench: ram_reader -> ramctl -> is61wv51216 model, with words preloaded through ramctl writes.
REQ-042 Basic burst: preload 4/5/6 = DEAD/BEEF/BABE, start_addr=4, len=3, out_ready=1 -> out_data DEAD, BEEF, BABE in order, then one done pulse.
REQ-043 Zero length: len=0 -> ram_ren never asserted, done pulses within 2 cycles, busy falls.
REQ-044 Wrap-around: start_addr=0x7FFFE, len=4 -> reads from 7FFFE, 7FFFF, 00000, 00001 in that order.
REQ-045 Backpressure: out_ready=0 for 20 cycles, len=8 -> at most FIFO_DEPTH reads issued (1 read without the macro), no words lost, order preserved after out_ready rises.
REQ-046 Abort: abort in REQ at the 2nd read -> the in-flight read completes, out_valid=0 afterwards, no done pulse, busy=0; a following start_addr=4, len=1 returns DEAD.
REQ-047 Reset mid-burst: rst during WAIT_SPACE -> all outputs at reset values on the next cycle; a following burst reads correctly.
